hazard_sequencer: RTL and testbench
===================================

Name: hazard_sequencer

Overview:
- Pipeline control block for the 16-bit 5-stage core. It sits beside the decode stage.
- Detects load-use and branch-operand hazards for the instruction held in IF/ID.
- Drives the PC/IF-ID write enables, the ID/EX bubble, the IF/ID flush on a taken branch/jump, and the decode comparator forwarding selects.
- Freezes the whole pipe while data memory reports busy.

Parameters:
- REG_AW, 3, register address width (8 architectural registers).
- CNT_W, 16, width of performance counters (optional feature only).

Ports:
- CLK  in  1  pipeline clock
- Reset  in  1  synchronous, active-high
- id_rs1  in  REG_AW  IF/ID source 1 (ir[8:6])
- id_rs2  in  REG_AW  IF/ID source 2 (ir[11:9])
- id_use_rs1 / id_use_rs2  in  1  instruction reads that source
- id_is_branch  in  1  ID instruction compares operands in decode (branch)
- jump_taken  in  1  decode redirect (branch taken or jump)
- ex_rd  in  REG_AW  ID/EX destination
- ex_regwrite, ex_memread  in  1  ID/EX control
- mem_rd  in  REG_AW  EX/MEM destination
- mem_regwrite, mem_memread  in  1  EX/MEM control
- mem_busy  in  1  data memory not ready this cycle
- pc_write  out  1  PC register enable
- ifid_write  out  1  IF/ID enable
- ifid_flush  out  1  IF/ID loads NOP at next edge
- idex_bubble  out  1  ID/EX loads all-zero control
- pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
- cmp_fwd1_sel, cmp_fwd2_sel  out  1  1 = comparator takes the forwarded value, 0 = register file value
- state_o  out  2  FSM state, for debug

Behaviour:
- Register 0 is never a hazard source: any match with rd==0 is ignored.
- src_hit(s, rd, wr) = id_use_s && wr && rd==s && rd!=0.
- Hazard classes, evaluated combinationally every cycle in RUN:
  - LU: src_hit against EX with ex_memread=1. Needs 1 stall cycle.
  - BR_EX: id_is_branch and src_hit against EX with ex_memread=0. Needs 1 stall cycle; the value is forwarded from MEM next cycle.
  - BR_LD: id_is_branch and src_hit against EX with ex_memread=1. Needs 2 stall cycles.
  - BR_MEMLD: id_is_branch and src_hit against MEM with mem_memread=1. Needs 1 stall cycle.
- Forwarding: cmp_fwdN_sel = id_is_branch && src_hit(rsN, mem_rd, mem_regwrite) && !mem_memread. Forced to 0 during any stall or freeze.
- Stall outputs: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
- Run outputs: pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=jump_taken.
- jump_taken is masked (no flush) while any hazard or stall is active. Branch resolution waits for valid operands.
- FSM states: RUN=0, STALL=1, FREEZE=2. The stall counter scnt is 1 bit.
  - RUN, mem_busy=1: go to FREEZE, ret=RUN.
  - RUN, BR_LD detected: stall this cycle, scnt<=1, go to STALL.
  - RUN, other hazard: stall this cycle, stay in RUN; the hazard is re-evaluated next cycle.
  - RUN, no hazard: run outputs.
  - STALL: stall outputs with no hazard evaluation. scnt==1 → scnt<=0 and go to RUN. mem_busy=1 → FREEZE with ret=STALL, scnt retained.
  - FREEZE: pipe_freeze=1, pc_write=0, ifid_write=0, idex_bubble=0, ifid_flush=0. Leave to ret when mem_busy==0 is sampled. The exit cycle itself still freezes; outputs resume the cycle after.
- Priority: mem_busy > STALL state > hazard > jump flush.
- Reset: state<=RUN, scnt<=0, ret<=RUN. While Reset=1, outputs are pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, pipe_freeze=0, fwd sels=0. Reset mid-STALL or mid-FREEZE abandons that state immediately.
- Latency: hazard detection and flush are same-cycle combinational. State changes take effect at the next CLK edge.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds output ports stall_cycles and flush_count, CNT_W each.
  - stall_cycles increments on each cycle with stall outputs.
  - flush_count increments on each cycle with ifid_flush while Reset=0.
  - Both counters saturate at all-ones and clear on Reset.
- When undefined, the ports are absent and the logic is removed. Core behaviour is identical either way.

Decomposition:
- Shared package cpu_pkg holds:
  - REG_AW
  - state encodings ST_RUN / ST_STALL / ST_FREEZE
  - the NOP instruction constant used by the IF/ID flush
- One sub-module, hazard_detect, is natural: the pure combinational class decode producing LU, BR_EX, BR_LD, BR_MEMLD and the fwd sels.
- The FSM and counters stay in the top module.

Test Plan:
- Reset held 2 cycles → pc_write=0, ifid_flush=1, idex_bubble=1, state_o=0. Release → pc_write=1, ifid_write=1.
- Load-use: ex_memread=1, ex_rd=3, id_rs1=3, use_rs1=1 → exactly 1 cycle of pc_write=0 and idex_bubble=1, then run.
- Branch on load: id_is_branch=1, ex_memread=1, ex_rd=2, id_rs2=2 → 2 stall cycles (state_o 0→1→0), then cmp_fwd2_sel=0 with normal run.
- Branch forward: mem_regwrite=1, mem_memread=0, mem_rd=5, id_rs1=5, id_is_branch=1 → cmp_fwd1_sel=1, no stall. With mem_rd=0 → sel=0.
- mem_busy for 3 cycles during STALL → pipe_freeze=1 for 4 cycles, then STALL resumes its remaining cycle and returns to RUN.
- jump_taken=1 with no hazard → ifid_flush=1 same cycle. jump_taken=1 with a concurrent LU hazard → ifid_flush=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared constants and types for the 16-bit 5-stage core's control.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int REG_AW = 3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_FREEZE = 2'd2
    } state_t;

    // Encoding loaded into IF/ID when a taken branch/jump flushes it.
    localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// ============================================================================
// Module : hazard_detect
// Brief  : Combinational hazard-class decode and comparator forwarding selects.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_detect #(
    parameter int REG_AW = cpu_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic              id_is_branch_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_regwrite_i,
    input  logic              ex_memread_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_regwrite_i,
    input  logic              mem_memread_i,
    output logic              lu_o,
    output logic              br_ex_o,
    output logic              br_ld_o,
    output logic              br_memld_o,
    output logic              fwd1_o,
    output logic              fwd2_o
);

    // r0 is hardwired zero, so a write to it never creates a dependency.
    function automatic logic src_hit(input logic use_s, input logic [REG_AW-1:0] s,
                                     input logic [REG_AW-1:0] rd, input logic wr);
        return use_s && wr && (rd == s) && (rd != '0);
    endfunction

    logic ex_hit;
    logic mem_hit1;
    logic mem_hit2;

    assign ex_hit   = src_hit(id_use_rs1_i, id_rs1_i, ex_rd_i, ex_regwrite_i)
                    | src_hit(id_use_rs2_i, id_rs2_i, ex_rd_i, ex_regwrite_i);
    assign mem_hit1 = src_hit(id_use_rs1_i, id_rs1_i, mem_rd_i, mem_regwrite_i);
    assign mem_hit2 = src_hit(id_use_rs2_i, id_rs2_i, mem_rd_i, mem_regwrite_i);

    assign lu_o       = ex_hit && ex_memread_i;
    assign br_ex_o    = id_is_branch_i && ex_hit && !ex_memread_i;
    assign br_ld_o    = id_is_branch_i && ex_hit && ex_memread_i;
    assign br_memld_o = id_is_branch_i && (mem_hit1 || mem_hit2) && mem_memread_i;
    assign fwd1_o     = id_is_branch_i && mem_hit1 && !mem_memread_i;
    assign fwd2_o     = id_is_branch_i && mem_hit2 && !mem_memread_i;

endmodule

`default_nettype wire

// File: rtl/hazard_sequencer.sv
// ============================================================================
// Module : hazard_sequencer
// Brief  : Stall/flush/freeze sequencer beside decode. Optional performance
//          counters are enabled with the HAZARD_PERF_CNT_EN macro.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_sequencer #(
    parameter int REG_AW = cpu_pkg::REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_is_branch,
    input  logic              jump_taken,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic              mem_memread,
    input  logic              mem_busy,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              pipe_freeze,
    output logic              cmp_fwd1_sel,
    output logic              cmp_fwd2_sel,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count,
`endif
    output logic [1:0]        state_o
);
    import cpu_pkg::*;

    state_t state_q, state_d;
    state_t ret_q, ret_d;
    logic   scnt_q, scnt_d;
    logic   stall_act;

    logic lu, br_ex, br_ld, br_memld, fwd1, fwd2, hazard;

    hazard_detect #(.REG_AW(REG_AW)) u_detect (
        .id_rs1_i       (id_rs1),
        .id_rs2_i       (id_rs2),
        .id_use_rs1_i   (id_use_rs1),
        .id_use_rs2_i   (id_use_rs2),
        .id_is_branch_i (id_is_branch),
        .ex_rd_i        (ex_rd),
        .ex_regwrite_i  (ex_regwrite),
        .ex_memread_i   (ex_memread),
        .mem_rd_i       (mem_rd),
        .mem_regwrite_i (mem_regwrite),
        .mem_memread_i  (mem_memread),
        .lu_o           (lu),
        .br_ex_o        (br_ex),
        .br_ld_o        (br_ld),
        .br_memld_o     (br_memld),
        .fwd1_o         (fwd1),
        .fwd2_o         (fwd2)
    );

    assign hazard  = lu | br_ex | br_ld | br_memld;
    assign state_o = state_q;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= ST_RUN;
            ret_q   <= ST_RUN;
            scnt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            scnt_q  <= scnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        scnt_d       = scnt_q;
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        pipe_freeze  = 1'b0;
        cmp_fwd1_sel = 1'b0;
        cmp_fwd2_sel = 1'b0;
        stall_act    = 1'b0;
        if (Reset) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mem_busy) begin
                        pipe_freeze = 1'b1;
                        ret_d       = ST_RUN;
                        state_d     = ST_FREEZE;
                    end else if (hazard) begin
                        stall_act   = 1'b1;
                        idex_bubble = 1'b1;
                        // Only a branch on a load needs a second, unconditional stall.
                        if (br_ld) begin
                            scnt_d  = 1'b1;
                            state_d = ST_STALL;
                        end
                    end else begin
                        pc_write     = 1'b1;
                        ifid_write   = 1'b1;
                        ifid_flush   = jump_taken;
                        cmp_fwd1_sel = fwd1;
                        cmp_fwd2_sel = fwd2;
                    end
                end
                ST_STALL: begin
                    if (mem_busy) begin
                        // scnt is kept so the pending stall cycle resumes after the freeze.
                        pipe_freeze = 1'b1;
                        ret_d       = ST_STALL;
                        state_d     = ST_FREEZE;
                    end else begin
                        stall_act   = 1'b1;
                        idex_bubble = 1'b1;
                        scnt_d      = 1'b0;
                        state_d     = ST_RUN;
                    end
                end
                ST_FREEZE: begin
                    pipe_freeze = 1'b1;
                    if (!mem_busy) begin
                        state_d = ret_q;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_act && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (ifid_flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;
`else
    logic [CNT_W-1:0] unused_perf_cnt;
    assign unused_perf_cnt = {CNT_W{stall_act}};
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_sequencer.sv
// ============================================================================
// Module : tb_hazard_sequencer
// Brief  : Self-checking bench for hazard_sequencer (vector table + sequences).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_sequencer;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic [2:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0, mem_rd = '0;
    logic       id_use_rs1 = 0, id_use_rs2 = 0, id_is_branch = 0, jump_taken = 0;
    logic       ex_regwrite = 0, ex_memread = 0, mem_regwrite = 0, mem_memread = 0;
    logic       mem_busy = 0;
    logic       pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze;
    logic       cmp_fwd1_sel, cmp_fwd2_sel;
    logic [1:0] state_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cycles, flush_count;
`endif

    hazard_sequencer dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_is_branch (id_is_branch),
        .jump_taken   (jump_taken),
        .ex_rd        (ex_rd),
        .ex_regwrite  (ex_regwrite),
        .ex_memread   (ex_memread),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .mem_memread  (mem_memread),
        .mem_busy     (mem_busy),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .pipe_freeze  (pipe_freeze),
        .cmp_fwd1_sel (cmp_fwd1_sel),
        .cmp_fwd2_sel (cmp_fwd2_sel),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count),
`endif
        .state_o      (state_o)
    );

    always #5 CLK = ~CLK;

    // Expected output word: {pc_write, ifid_write, ifid_flush, idex_bubble,
    //                        pipe_freeze, fwd1, fwd2, state[1:0]}
    localparam logic [6:0] O_RUN   = 7'b1100000;
    localparam logic [6:0] O_FLUSH = 7'b1110000;
    localparam logic [6:0] O_STALL = 7'b0001000;
    localparam logic [6:0] O_FRZ   = 7'b0000100;
    localparam logic [6:0] O_RST   = 7'b0011000;

    typedef struct {
        string      name;
        logic       rst;
        logic [2:0] rs1, rs2, ex_rd, mem_rd;
        logic       use1, use2, br, jt, ex_rw, ex_mr, mem_rw, mem_mr, busy;
        logic [8:0] exp;
    } vec_t;

    vec_t       tbl[$];
    logic [8:0] sb_exp[$];
    string      sb_name[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    function automatic vec_t mk(input string n, input logic [6:0] o, input logic [1:0] st);
        vec_t v;
        v.name = n; v.rst = 0;
        v.rs1 = 0; v.rs2 = 0; v.ex_rd = 0; v.mem_rd = 0;
        v.use1 = 0; v.use2 = 0; v.br = 0; v.jt = 0;
        v.ex_rw = 0; v.ex_mr = 0; v.mem_rw = 0; v.mem_mr = 0; v.busy = 0;
        v.exp = {o, st};
        return v;
    endfunction

    // Load in EX writing r3, IF/ID reads r3 through rs1.
    function automatic vec_t with_lu(input vec_t v);
        v.ex_mr = 1; v.ex_rw = 1; v.ex_rd = 3; v.rs1 = 3; v.use1 = 1;
        return v;
    endfunction

    // Branch in IF/ID whose rs2 (r2) is the target of a load in EX.
    function automatic vec_t with_brld(input vec_t v);
        v.br = 1; v.ex_mr = 1; v.ex_rw = 1; v.ex_rd = 2; v.rs2 = 2; v.use2 = 1;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        @(posedge CLK);
        #1;
        Reset = v.rst;
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.use1; id_use_rs2 = v.use2;
        id_is_branch = v.br; jump_taken = v.jt;
        ex_rd = v.ex_rd; ex_regwrite = v.ex_rw; ex_memread = v.ex_mr;
        mem_rd = v.mem_rd; mem_regwrite = v.mem_rw; mem_memread = v.mem_mr;
        mem_busy = v.busy;
        @(negedge CLK);
    endtask

    task automatic check_bit(input string n, input logic act, input logic req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", n, act, req);
        end
    endtask

    task automatic check_sb();
        logic [8:0] act, req;
        string      n;
        n_checks++;
        if (sb_exp.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: output sampled with no expectation queued");
            return;
        end
        req = sb_exp.pop_front();
        n   = sb_name.pop_front();
        act = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze,
               cmp_fwd1_sel, cmp_fwd2_sel, state_o};
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got pcw/ifw/fl/bub/frz/f1/f2/st=%b, expected %b", n, act, req);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   frz_cnt;

        v = mk("rst0", O_RST, 2'd0); v.rst = 1; tbl.push_back(v);
        v = mk("rst1", O_RST, 2'd0); v.rst = 1; tbl.push_back(v);
        tbl.push_back(mk("run_after_rst", O_RUN, 2'd0));
        tbl.push_back(with_lu(mk("lu_stall", O_STALL, 2'd0)));
        tbl.push_back(mk("lu_resume", O_RUN, 2'd0));
        v = with_lu(mk("lu_rd0", O_RUN, 2'd0)); v.ex_rd = 0; v.rs1 = 0; tbl.push_back(v);
        v = with_lu(mk("lu_unused_src", O_RUN, 2'd0)); v.use1 = 0; tbl.push_back(v);
        tbl.push_back(with_brld(mk("brld_stall1", O_STALL, 2'd0)));
        v = mk("brld_stall2", O_STALL, 2'd1);
        v.br = 1; v.rs2 = 2; v.use2 = 1; v.mem_rd = 2; v.mem_rw = 1; v.mem_mr = 1;
        tbl.push_back(v);
        v = mk("brld_run", O_RUN, 2'd0); v.br = 1; v.rs2 = 2; v.use2 = 1; v.mem_rd = 2;
        tbl.push_back(v);
        v = mk("br_fwd1", O_RUN | 7'b0000010, 2'd0);
        v.br = 1; v.mem_rw = 1; v.mem_rd = 5; v.rs1 = 5; v.use1 = 1; tbl.push_back(v);
        v = mk("br_fwd_r0", O_RUN, 2'd0);
        v.br = 1; v.mem_rw = 1; v.mem_rd = 0; v.rs1 = 0; v.use1 = 1; tbl.push_back(v);
        v = mk("br_fwd_both_jt", O_FLUSH | 7'b0000011, 2'd0);
        v.br = 1; v.jt = 1; v.mem_rw = 1; v.mem_rd = 4; v.rs1 = 4; v.rs2 = 4;
        v.use1 = 1; v.use2 = 1; tbl.push_back(v);
        v = mk("br_ex_jt_masked", O_STALL, 2'd0);
        v.br = 1; v.jt = 1; v.ex_rw = 1; v.ex_rd = 6; v.rs1 = 6; v.use1 = 1;
        tbl.push_back(v);
        v = mk("br_memld", O_STALL, 2'd0);
        v.br = 1; v.mem_rw = 1; v.mem_mr = 1; v.mem_rd = 7; v.rs2 = 7; v.use2 = 1;
        tbl.push_back(v);
        v = mk("jump_flush", O_FLUSH, 2'd0); v.jt = 1; tbl.push_back(v);
        v = with_lu(mk("jump_lu_masked", O_STALL, 2'd0)); v.jt = 1; tbl.push_back(v);
        v = mk("busy_in_run", O_FRZ, 2'd0); v.busy = 1; v.jt = 1; tbl.push_back(v);
        v = mk("freeze_exit", O_FRZ, 2'd2); v.jt = 1; tbl.push_back(v);
        tbl.push_back(mk("run_after_freeze", O_RUN, 2'd0));
        tbl.push_back(with_brld(mk("brld_then_rst", O_STALL, 2'd0)));
        v = mk("rst_mid_stall", O_RST, 2'd1); v.rst = 1; tbl.push_back(v);
        tbl.push_back(mk("run_after_rst_stall", O_RUN, 2'd0));
        v = mk("busy_then_rst", O_FRZ, 2'd0); v.busy = 1; tbl.push_back(v);
        v = mk("rst_mid_freeze", O_RST, 2'd2); v.rst = 1; v.busy = 1; tbl.push_back(v);
        tbl.push_back(mk("run_after_rst_freeze", O_RUN, 2'd0));

        foreach (tbl[i]) begin
            sb_exp.push_back(tbl[i].exp);
            sb_name.push_back(tbl[i].name);
            drive(tbl[i]);
            check_sb();
        end

        // Memory busy for 3 cycles while in STALL: freeze lasts 4 cycles,
        // then the pending stall cycle runs before returning to RUN.
        drive(with_brld(mk("seq_brld", O_STALL, 2'd0)));
        check_bit("seq_brld_stall", idex_bubble, 1'b1);
        frz_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            v = mk("seq_busy", O_FRZ, 2'd0); v.busy = 1;
            drive(v);
            if (pipe_freeze) frz_cnt++;
        end
        for (int k = 0; k < 8; k++) begin
            drive(mk("seq_idle", O_RUN, 2'd0));
            if (!pipe_freeze) break;
            frz_cnt++;
        end
        n_checks++;
        if (frz_cnt != 4) begin
            n_fail++;
            $display("FAIL freeze_len: got %0d cycles, expected 4", frz_cnt);
        end
        check_bit("resume_state_is_stall", state_o == 2'd1, 1'b1);
        check_bit("resume_pc_write", pc_write, 1'b0);
        check_bit("resume_bubble", idex_bubble, 1'b1);
        drive(mk("seq_run", O_RUN, 2'd0));
        check_bit("back_to_run_state", state_o == 2'd0, 1'b1);
        check_bit("back_to_run_pcw", pc_write, 1'b1);
        check_bit("back_to_run_fwd2", cmp_fwd2_sel, 1'b0);

        n_checks++;
        if (sb_exp.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_exp.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
